// File: rtl/t05_instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the team-05 PC/ALU datapath.
// Drives bus requests, PC strobes and register-file write enable.
module t05_instr_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             en,
  input  logic [6:0]       opcode,
  input  logic             mem_ack,
  output logic             i_req,
  output logic             instr_latch,
  output logic             d_ren,
  output logic             d_wen,
  output logic             reg_wen,
  output logic             pc_inc,
  output logic             pc_disable,
  output logic             pc_load,
  output logic [2:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] LIM = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } st_t;

  st_t           st;
  logic [TW-1:0] wcnt;
  logic          ld_q;
  logic          sd_q;

  logic is_ld;
  logic is_sd;
  logic is_br;
  logic is_jalr;
  logic legal;
  logic ecall;

  always_comb begin
    is_ld   = 1'b0;
    is_sd   = 1'b0;
    is_br   = 1'b0;
    is_jalr = 1'b0;
    legal   = 1'b0;
    ecall   = 1'b0;
    case (opcode)
      7'b0110011: legal = 1'b1;
      7'b0010011: legal = 1'b1;
      7'b0000011: begin legal = 1'b1; is_ld = 1'b1; end
      7'b0100011: begin legal = 1'b1; is_sd = 1'b1; end
      7'b1100011: begin legal = 1'b1; is_br = 1'b1; end
      7'b1101111: legal = 1'b1;
      7'b1100111: begin legal = 1'b1; is_jalr = 1'b1; end
      7'b0110111: legal = 1'b1;
      7'b1110011: ecall = 1'b1;
      default:    legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      st      <= S_FETCH;
      wcnt    <= '0;
      ld_q    <= 1'b0;
      sd_q    <= 1'b0;
      retired <= '0;
    end else begin
      unique case (st)
        S_FETCH: begin
          if (en) begin
            if (mem_ack)          st   <= S_DECODE;
            else if (wcnt == LIM) st   <= S_ERROR;
            else                  wcnt <= wcnt + 1'b1;
          end
        end
        S_DECODE: begin
          if (legal)      st <= S_EXEC;
          else if (ecall) st <= S_HALT;
          else            st <= S_ERROR;
        end
        S_EXEC: begin
          ld_q <= is_ld;
          sd_q <= is_sd;
          wcnt <= '0;
          st   <= (is_ld || is_sd) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (mem_ack)          st   <= S_WB;
          else if (wcnt == LIM) st   <= S_ERROR;
          else                  wcnt <= wcnt + 1'b1;
        end
        S_WB: begin
          retired <= retired + CNT_W'(1);
          wcnt    <= '0;
          ld_q    <= 1'b0;
          sd_q    <= 1'b0;
          st      <= S_FETCH;
        end
        S_HALT:  st <= S_HALT;
        S_ERROR: st <= S_ERROR;
        default: st <= S_ERROR;
      endcase
    end
  end

  // opcode is held stable through WB, so WB strobes decode it directly
  assign state       = st;
  assign i_req       = (st == S_FETCH) && en;
  assign instr_latch = (st == S_FETCH) && en && mem_ack;
  assign d_ren       = (st == S_MEM) && ld_q;
  assign d_wen       = (st == S_MEM) && sd_q;
  assign reg_wen     = (st == S_WB) && !(is_sd || is_br);
  assign pc_load     = (st == S_WB) && is_jalr;
  assign pc_inc      = (st == S_WB) && !is_jalr;
  assign pc_disable  = (st != S_WB);
  assign err         = (st == S_ERROR);

endmodule
